// File: rtl/wave_seq_pp.sv
// rtl/wave_seq_pp.sv - ping-pong waveform sequencer driving a DAC at a programmable tick rate
// Words are {end, hold, sample}; each sample is held (hold+1) ticks, with loop/continuous replay.
module wave_seq_pp #(
  parameter int DATA_W = 10,
  parameter int HOLD_W = 6,
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 8,
  parameter int LOOP_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wr_en_i,
  input  logic [1:0]               wr_bank_msk_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W+HOLD_W:0]   wr_word_i,
  input  logic                     bank_sel_i,
  input  logic                     bank_swap_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [1:0]               mode_i,
  input  logic [LOOP_W-1:0]        loop_n_i,
  input  logic [DIV_W-1:0]         div_n_i,
  input  logic [DATA_W-1:0]        vol_max_i,
  input  logic                     set_en_i,
  input  logic [DATA_W-1:0]        set_value_i,
  output logic                     busy_o,
  output logic                     wave_end_o,
  output logic                     play_bank_o,
  output logic                     vol_err_o,
  output logic                     underrun_err_o,
  output logic                     wr_conflict_o,
  output logic [DATA_W-1:0]        da_data_o,
  output logic                     da_dclk_o
);

  localparam int W     = DATA_W + HOLD_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_DONE
  } state_e;

  state_e              state_q;
  logic                play_bank_q, swap_pend_q, pend_bank_q;
  logic [1:0]          mode_q;
  logic [LOOP_W-1:0]   passes_q;
  logic [ADDR_W-1:0]   start_addr_q, addr_q, rd_addr_q;
  logic [W-1:0]        cur_q, rd_data_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [DIV_W-1:0]    div_cnt_q;
  logic                pf_req_q, pf_valid_q;
  logic                wave_end_q, vol_err_q, underrun_q, wr_conflict_q, da_dclk_q;
  logic [DATA_W-1:0]   da_data_q;

  logic [W-1:0]        mem_a [DEPTH];
  logic [W-1:0]        mem_b [DEPTH];

  // Read port: address register (rd_addr_q) then output register, so data lags the issue by 2 clocks.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_bank_msk_i[0]) mem_a[wr_addr_i] <= wr_word_i;
    if (wr_en_i && wr_bank_msk_i[1]) mem_b[wr_addr_i] <= wr_word_i;
    rd_data_q <= play_bank_q ? mem_b[rd_addr_q] : mem_a[rd_addr_q];
  end

  logic [DATA_W-1:0] cur_sample, clamped;
  logic              cur_end, over, div_run, tick, last_pass, busy;

  assign cur_sample = cur_q[DATA_W-1:0];
  assign cur_end    = cur_q[W-1];
  assign over       = cur_sample > vol_max_i;
  assign clamped    = over ? vol_max_i : cur_sample;
  assign busy       = (state_q != S_IDLE);
  assign div_run    = (state_q == S_PLAY) || set_en_i;
  assign tick       = div_run && (div_cnt_q == div_n_i);
  assign last_pass  = (mode_q == 2'b00) || ((mode_q == 2'b01) && (passes_q == '0));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      play_bank_q   <= 1'b0;
      swap_pend_q   <= 1'b0;
      pend_bank_q   <= 1'b0;
      mode_q        <= 2'b00;
      passes_q      <= '0;
      start_addr_q  <= '0;
      addr_q        <= '0;
      rd_addr_q     <= '0;
      cur_q         <= '0;
      hold_q        <= '0;
      div_cnt_q     <= '0;
      pf_req_q      <= 1'b0;
      pf_valid_q    <= 1'b0;
      wave_end_q    <= 1'b0;
      vol_err_q     <= 1'b0;
      underrun_q    <= 1'b0;
      wr_conflict_q <= 1'b0;
      da_data_q     <= '0;
      da_dclk_q     <= 1'b0;
    end else begin
      wave_end_q <= 1'b0;
      da_dclk_q  <= tick;
      if (!div_run || tick) div_cnt_q <= '0;
      else                  div_cnt_q <= div_cnt_q + DIV_W'(1);

      if (set_en_i) begin
        da_data_q <= set_value_i;
      end else if (state_q == S_PLAY && tick) begin
        da_data_q <= clamped;
        if (over) vol_err_q <= 1'b1;
      end

      pf_req_q <= 1'b0;
      if (pf_req_q) pf_valid_q <= 1'b1;

      if (wr_en_i && busy && wr_bank_msk_i[play_bank_q]) wr_conflict_q <= 1'b1;

      if (abort_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (swap_pend_q) begin
              play_bank_q <= pend_bank_q;
              swap_pend_q <= 1'b0;
            end
            if (start_i) begin
              state_q       <= S_FETCH;
              addr_q        <= start_addr_i;
              start_addr_q  <= start_addr_i;
              mode_q        <= mode_i;
              passes_q      <= loop_n_i;
              vol_err_q     <= 1'b0;
              underrun_q    <= 1'b0;
              wr_conflict_q <= 1'b0;
            end
          end
          S_FETCH: begin
            rd_addr_q <= addr_q;
            state_q   <= S_WAIT;
          end
          S_WAIT: state_q <= S_LOAD;
          S_LOAD: begin
            cur_q      <= rd_data_q;
            hold_q     <= rd_data_q[DATA_W +: HOLD_W];
            addr_q     <= addr_q + ADDR_W'(1);
            rd_addr_q  <= addr_q + ADDR_W'(1);
            pf_req_q   <= 1'b1;
            pf_valid_q <= 1'b0;
            state_q    <= S_PLAY;
          end
          S_PLAY: begin
            if (tick) begin
              if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
              end else if (!cur_end) begin
                // Without a ready prefetch the current sample simply plays one more tick.
                if (pf_valid_q) begin
                  cur_q      <= rd_data_q;
                  hold_q     <= rd_data_q[DATA_W +: HOLD_W];
                  addr_q     <= addr_q + ADDR_W'(1);
                  rd_addr_q  <= addr_q + ADDR_W'(1);
                  pf_req_q   <= 1'b1;
                  pf_valid_q <= 1'b0;
                end else begin
                  underrun_q <= 1'b1;
                end
              end else if (last_pass) begin
                state_q <= S_DONE;
              end else begin
                if (mode_q == 2'b01) passes_q <= passes_q - LOOP_W'(1);
                if (swap_pend_q) begin
                  play_bank_q <= pend_bank_q;
                  swap_pend_q <= 1'b0;
                end
                addr_q  <= start_addr_q;
                state_q <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            state_q    <= S_IDLE;
            wave_end_q <= 1'b1;
            if (swap_pend_q) begin
              play_bank_q <= pend_bank_q;
              swap_pend_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      // Handled last so a swap request landing on a boundary clock is never dropped.
      if (bank_swap_i) begin
        if (state_q == S_IDLE && !abort_i) begin
          play_bank_q <= bank_sel_i;
          swap_pend_q <= 1'b0;
        end else begin
          swap_pend_q <= 1'b1;
          pend_bank_q <= bank_sel_i;
        end
      end
    end
  end

  assign busy_o         = busy;
  assign wave_end_o     = wave_end_q;
  assign play_bank_o    = play_bank_q;
  assign vol_err_o      = vol_err_q;
  assign underrun_err_o = underrun_q;
  assign wr_conflict_o  = wr_conflict_q;
  assign da_data_o      = da_data_q;
  assign da_dclk_o      = da_dclk_q;

endmodule

// File: tb/tb_wave_seq_pp.sv
// tb/tb_wave_seq_pp.sv - directed, table-driven bench for wave_seq_pp
module tb_wave_seq_pp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank_msk = 2'b00;
  logic [7:0]  wr_addr = '0;
  logic [16:0] wr_word = '0;
  logic        bank_sel = 1'b0, bank_swap = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  loop_n = '0;
  logic [7:0]  div_n = 8'd2;
  logic [9:0]  vol_max = 10'd1023;
  logic        set_en = 1'b0;
  logic [9:0]  set_value = '0;
  logic        busy, wave_end, play_bank, vol_err, underrun_err, wr_conflict, da_dclk;
  logic [9:0]  da_data;

  always #5 clk = ~clk;

  wave_seq_pp dut (
    .clk_i(clk), .rstn_i(rst_n), .wr_en_i(wr_en), .wr_bank_msk_i(wr_bank_msk),
    .wr_addr_i(wr_addr), .wr_word_i(wr_word), .bank_sel_i(bank_sel), .bank_swap_i(bank_swap),
    .start_i(start), .abort_i(abort), .start_addr_i(start_addr), .mode_i(mode),
    .loop_n_i(loop_n), .div_n_i(div_n), .vol_max_i(vol_max), .set_en_i(set_en),
    .set_value_i(set_value), .busy_o(busy), .wave_end_o(wave_end), .play_bank_o(play_bank),
    .vol_err_o(vol_err), .underrun_err_o(underrun_err), .wr_conflict_o(wr_conflict),
    .da_data_o(da_data), .da_dclk_o(da_dclk)
  );

  typedef struct {
    logic [7:0] sa;
    logic [9:0] s0;
    logic [5:0] h0;
    logic [9:0] s1;
    logic [5:0] h1;
    logic [7:0] dv;
    logic [1:0] md;
    logic [7:0] ln;
    logic [9:0] vm;
    int         pulses;
    logic [9:0] first;
    logic [9:0] last;
    int         gap;
    logic       vol;
    logic       ur;
  } vec_t;

  vec_t tbl[7];
  int checks = 0;
  int failures = 0;
  int npulse, t_first, t_second, t_last, t_end, cnt;
  logic [9:0] first_d, last_d, d;
  logic ok, found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [16:0] mkw(input logic e, input logic [5:0] h, input logic [9:0] s);
    return {e, h, s};
  endfunction

  task automatic wr(input logic [1:0] msk, input logic [7:0] a, input logic [16:0] w);
    wr_en = 1'b1; wr_bank_msk = msk; wr_addr = a; wr_word = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dclk(output logic got, output logic [9:0] val);
    got = 1'b0;
    val = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (da_dclk) begin
        got = 1'b1;
        val = da_data;
        break;
      end
    end
  endtask

  task automatic wait_end(output logic got);
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (wave_end) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    //          sa     s0   h0   s1   h1  div mode loop vmax  pulses first last gap vol ur
    tbl[0] = '{8'd0,   10'd100, 6'd1, 10'd200, 6'd0, 8'd2, 2'b00, 8'd0, 10'd1023, 3, 10'd100, 10'd200, 3, 1'b0, 1'b0};
    tbl[1] = '{8'd0,   10'd100, 6'd1, 10'd200, 6'd0, 8'd2, 2'b01, 8'd2, 10'd1023, 9, 10'd100, 10'd200, 3, 1'b0, 1'b0};
    tbl[2] = '{8'd0,   10'd900, 6'd0, 10'd300, 6'd0, 8'd3, 2'b00, 8'd0, 10'd800,  2, 10'd800, 10'd300, 4, 1'b1, 1'b0};
    tbl[3] = '{8'd255, 10'd5,   6'd2, 10'd7,   6'd0, 8'd2, 2'b00, 8'd0, 10'd1023, 4, 10'd5,   10'd7,   3, 1'b0, 1'b0};
    tbl[4] = '{8'd0,   10'd50,  6'd0, 10'd60,  6'd0, 8'd0, 2'b00, 8'd0, 10'd1023, 3, 10'd50,  10'd60,  1, 1'b0, 1'b1};
    tbl[5] = '{8'd10,  10'd10,  6'd0, 10'd20,  6'd1, 8'd2, 2'b01, 8'd0, 10'd1023, 3, 10'd10,  10'd20,  3, 1'b0, 1'b0};
    tbl[6] = '{8'd0,   10'd800, 6'd0, 10'd800, 6'd0, 8'd2, 2'b00, 8'd0, 10'd800,  2, 10'd800, 10'd800, 3, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({busy, wave_end, play_bank, vol_err, underrun_err, wr_conflict, da_data, da_dclk}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      wr(2'b01, tbl[i].sa, mkw(1'b0, tbl[i].h0, tbl[i].s0));
      wr(2'b01, tbl[i].sa + 8'd1, mkw(1'b1, tbl[i].h1, tbl[i].s1));
      div_n = tbl[i].dv; mode = tbl[i].md; loop_n = tbl[i].ln;
      vol_max = tbl[i].vm; start_addr = tbl[i].sa;
      pulse_start();
      npulse = 0; t_first = -1; t_second = -1; t_last = -1; t_end = -1;
      first_d = '0; last_d = '0;
      for (int c = 0; c < 600 && t_end < 0; c++) begin
        @(negedge clk);
        if (da_dclk) begin
          if (npulse == 0) begin first_d = da_data; t_first = c; end
          else if (npulse == 1) t_second = c;
          last_d = da_data;
          t_last = c;
          npulse++;
        end
        if (wave_end) t_end = c;
      end
      chk($sformatf("v%0d_pulses", i), 32'(npulse), 32'(tbl[i].pulses));
      chk($sformatf("v%0d_first", i), 32'(first_d), 32'(tbl[i].first));
      chk($sformatf("v%0d_last", i), 32'(last_d), 32'(tbl[i].last));
      chk($sformatf("v%0d_gap", i), 32'(t_second - t_first), 32'(tbl[i].gap));
      chk($sformatf("v%0d_end_lat", i), 32'(t_end - t_last), 32'd1);
      chk($sformatf("v%0d_vol_err", i), 32'(vol_err), 32'(tbl[i].vol));
      chk($sformatf("v%0d_underrun", i), 32'(underrun_err), 32'(tbl[i].ur));
      chk($sformatf("v%0d_wr_conflict", i), 32'(wr_conflict), 32'd0);
      chk($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Continuous on A, swap requested mid-pass: the A pass finishes, then B plays.
    wr(2'b01, 8'd0, mkw(1'b0, 6'd0, 10'd111));
    wr(2'b01, 8'd1, mkw(1'b1, 6'd0, 10'd222));
    wr(2'b10, 8'd0, mkw(1'b0, 6'd0, 10'd333));
    wr(2'b10, 8'd1, mkw(1'b1, 6'd0, 10'd444));
    vol_max = 10'd1023; div_n = 8'd2; mode = 2'b10; bank_sel = 1'b0; start_addr = 8'd0;
    pulse_start();
    wait_dclk(ok, d);
    chk("swap_first", 32'(d), 32'd111);
    bank_sel = 1'b1; bank_swap = 1'b1;
    @(negedge clk);
    bank_swap = 1'b0;
    chk("swap_deferred", 32'(play_bank), 32'd0);
    wait_dclk(ok, d);
    chk("swap_a_completes", 32'(d), 32'd222);
    wait_dclk(ok, d);
    chk("swap_b_first", 32'(d), 32'd333);
    chk("swap_bank_now_b", 32'(play_bank), 32'd1);
    wait_dclk(ok, d);
    chk("swap_b_second", 32'(d), 32'd444);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (wave_end) cnt++;
    end
    chk("abort_no_wave_end", 32'(cnt), 32'd0);
    bank_sel = 1'b0; bank_swap = 1'b1;
    @(negedge clk);
    bank_swap = 1'b0;
    chk("idle_swap", 32'(play_bank), 32'd0);

    // Writes while playing A: other bank is harmless, play bank flags a conflict but still lands.
    mode = 2'b10;
    pulse_start();
    repeat (2) @(negedge clk);
    chk("busy_running", 32'(busy), 32'd1);
    wr(2'b10, 8'd5, mkw(1'b0, 6'd0, 10'd1));
    chk("no_conflict_other_bank", 32'(wr_conflict), 32'd0);
    wr(2'b01, 8'd1, mkw(1'b1, 6'd0, 10'd555));
    chk("wr_conflict_set", 32'(wr_conflict), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      wait_dclk(ok, d);
      if (ok && d == 10'd555) found = 1'b1;
    end
    chk("write_while_busy", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("conflict_sticky", 32'(wr_conflict), 32'd1);
    mode = 2'b00;
    pulse_start();
    chk("sticky_clear", 32'(wr_conflict), 32'd0);
    wait_end(ok);
    chk("single_after_clear_end", 32'(ok), 32'd1);
    @(negedge clk);

    // Manual override in IDLE: dclk still follows the divider, no clamp.
    vol_max = 10'h100; div_n = 8'd3; set_value = 10'h155; set_en = 1'b1;
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (da_dclk) cnt++;
    end
    chk("set_dclk_count", 32'(cnt), 32'd4);
    chk("set_value", 32'(da_data), 32'h155);
    chk("set_no_vol_err", 32'(vol_err), 32'd0);
    set_en = 1'b0;
    @(negedge clk);

    // Play B with clamp, then drop reset mid-PLAY between clock edges.
    bank_sel = 1'b1; bank_swap = 1'b1;
    @(negedge clk);
    bank_swap = 1'b0;
    vol_max = 10'd100; mode = 2'b10; div_n = 8'd2;
    pulse_start();
    wait_dclk(ok, d);
    chk("clamp_b", 32'(d), 32'd100);
    chk("clamp_vol_err", 32'(vol_err), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outs", 32'({busy, wave_end, play_bank, vol_err, underrun_err, wr_conflict, da_data, da_dclk}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
